// File: rtl/counter_dflipflop_sync_down_4bit_pkg.sv
// Shared constants and state encoding for the 4-bit loadable down counter.
// Imported by the RTL and by its testbench.
package counter_dflipflop_sync_down_4bit_pkg;

   localparam int WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUN     = 2'b01,
      EXPIRED = 2'b10
   } state_t;

   localparam logic [WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

   // Every storage bit of the counter, flattened into one vector of flops
   typedef struct packed {
      state_t           state;
      logic [WIDTH-1:0] period;
      logic [WIDTH-1:0] count;
      logic             done;
   } regs_t;

endpackage

// File: rtl/counter_dflipflop_sync_down_4bit_dff.sv
// Single storage bit: rising-edge D flip-flop with asynchronous active-high clear.
module counter_dflipflop_sync_down_4bit_dff (
   input  logic D,
   input  logic Clk,
   input  logic Clr,
   output logic Q
);

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) Q <= 1'b0;
      else     Q <= D;
   end

endmodule

// File: rtl/counter_dflipflop_sync_down_4bit.sv
// 4-bit down counter with parallel load, one-shot/periodic modes and a Done pulse.
// All state lives in discrete clearable flip-flops; next-state logic is combinational.
module counter_dflipflop_sync_down_4bit
   import counter_dflipflop_sync_down_4bit_pkg::*;
(
   input  logic             Clk,
   input  logic             Clr,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadVal,
   input  logic             En,
   input  logic             Reload,
   output logic [WIDTH-1:0] count,
   output logic             Zero,
   output logic             Done
);

   localparam int REG_BITS = $bits(regs_t);

   regs_t               cur;
   regs_t               nxt;
   logic [REG_BITS-1:0] d_bits;
   logic [REG_BITS-1:0] q_bits;

   assign d_bits = nxt;
   assign cur    = q_bits;

   generate
      for (genvar gi = 0; gi < REG_BITS; gi++) begin : g_bit
         counter_dflipflop_sync_down_4bit_dff u_bit (
            .D  (d_bits[gi]),
            .Clk(Clk),
            .Clr(Clr),
            .Q  (q_bits[gi])
         );
      end
   endgenerate

   always_comb begin
      nxt      = cur;
      nxt.done = 1'b0;
      if (Load) begin
         // Load wins over any terminal event on the same edge
         nxt.count  = LoadVal;
         nxt.period = LoadVal;
         nxt.state  = (LoadVal != CNT_ZERO) ? RUN : IDLE;
      end else if (cur.state == RUN && En) begin
         if (cur.count > CNT_ONE) begin
            nxt.count = cur.count - CNT_ONE;
         end else if (cur.count == CNT_ONE) begin
            nxt.done = 1'b1;
            if (Reload) begin
               nxt.count = cur.period;
            end else begin
               nxt.count = CNT_ZERO;
               nxt.state = EXPIRED;
            end
         end
      end
   end

   assign count = cur.count;
   assign Done  = cur.done;
   assign Zero  = (cur.count == CNT_ZERO);

endmodule
